exu_agu: RTL and testbench

- Address-generation and load/store sequencing stage that sits directly upstream of the memory unit (mem_top).
- Accepts one decoded load/store per handshake from the execute dispatch and computes the effective address rs1+imm.
- Builds byte lanes, write mask and misalignment flag, issues one command to mem_top, and waits for its completion.
- Formats the returned word (lane extract, sign/zero extend) and presents a single writeback beat to the regfile/commit stage.

---
 rtl/exu_agu.sv | 229 ++++++++++++++++++++++
 tb/tb_exu_agu.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_agu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// exu_agu
// Address generation and load/store sequencing stage in front of mem_top.
// Takes one decoded load/store from dispatch, forms rs1+imm, builds the byte
// mask, replicated store data and misalignment flag, issues a single command
// to mem_top and waits for its response. The returned word is lane-extracted
// and extended, then presented as one writeback beat.
//
// Ports
//   clk, rst_n               core clock, async active-low reset
//   agu_i_valid/agu_o_ready  dispatch handshake (ready only in IDLE)
//   agu_i_load/store/usign/size/rs1/rs2/imm/rd_idx  decoded instruction
//   agu_i_flush              pipeline flush / trap
//   agu_o_cmd_*              registered command fields to mem_top
//   agu_o_mem_valid/agu_i_mem_ready  command handshake
//   agu_i_mem_rdata/err      memory response
//   agu_o_wbck_*/agu_i_wbck_ready    writeback beat to regfile/commit
// -----------------------------------------------------------------------------
module exu_agu #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               agu_i_valid,
  output logic               agu_o_ready,
  input  logic               agu_i_load,
  input  logic               agu_i_store,
  input  logic               agu_i_usign,
  input  logic [1:0]         agu_i_size,
  input  logic [XLEN-1:0]    agu_i_rs1,
  input  logic [XLEN-1:0]    agu_i_rs2,
  input  logic [XLEN-1:0]    agu_i_imm,
  input  logic [RFIDX_W-1:0] agu_i_rd_idx,
  input  logic               agu_i_flush,
  output logic               agu_o_cmd_enable,
  output logic               agu_o_cmd_read,
  output logic               agu_o_cmd_write,
  output logic               agu_o_cmd_usign,
  output logic [1:0]         agu_o_cmd_size,
  output logic [PC_SIZE-1:0] agu_o_cmd_addr,
  output logic [XLEN-1:0]    agu_o_cmd_wdata,
  output logic [XLEN/8-1:0]  agu_o_cmd_wmask,
  output logic               agu_o_cmd_misalgn,
  output logic               agu_o_mem_valid,
  input  logic               agu_i_mem_ready,
  input  logic [XLEN-1:0]    agu_i_mem_rdata,
  input  logic               agu_i_mem_err,
  output logic               agu_o_wbck_valid,
  input  logic               agu_i_wbck_ready,
  output logic               agu_o_wbck_rd_en,
  output logic [RFIDX_W-1:0] agu_o_wbck_rd_idx,
  output logic [XLEN-1:0]    agu_o_wbck_data,
  output logic               agu_o_wbck_err
);

  localparam int NB = XLEN / 8;
  localparam logic [NB-1:0] LANE_B = {{(NB-1){1'b0}}, 1'b1};
  localparam logic [NB-1:0] LANE_H = {{(NB-2){1'b0}}, 2'b11};

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_WBCK} state_e;

  state_e               state_q;
  logic                 cmd_enable_q, cmd_read_q, cmd_write_q, cmd_usign_q;
  logic [1:0]           cmd_size_q;
  logic [PC_SIZE-1:0]   cmd_addr_q;
  logic [XLEN-1:0]      cmd_wdata_q;
  logic [NB-1:0]        cmd_wmask_q;
  logic                 cmd_misalgn_q;
  logic [RFIDX_W-1:0]   rd_idx_q;
  logic                 mem_valid_q;
  logic                 flushed_q;
  logic                 wbck_valid_q, wbck_rd_en_q, wbck_err_q;
  logic [RFIDX_W-1:0]   wbck_rd_idx_q;
  logic [XLEN-1:0]      wbck_data_q;

  logic [XLEN-1:0]      sum_d;
  logic [PC_SIZE-1:0]   addr_d;
  logic                 accept_d;
  logic                 misalgn_d;
  logic [NB-1:0]        wmask_d;
  logic [XLEN-1:0]      wdata_d;
  logic [XLEN-1:0]      shifted_d;
  logic [XLEN-1:0]      ld_data_d;
  logic                 resp_err_d;

  assign sum_d    = agu_i_rs1 + agu_i_imm;
  assign addr_d   = sum_d[PC_SIZE-1:0];
  assign accept_d = (state_q == ST_IDLE) & agu_i_valid &
                    (agu_i_load | agu_i_store) & ~agu_i_flush;

  // Request-side decode, evaluated on the incoming instruction.
  always_comb begin
    misalgn_d = 1'b0;
    wmask_d   = '0;
    wdata_d   = agu_i_rs2;
    case (agu_i_size)
      2'b00: begin
        wmask_d = LANE_B << addr_d[1:0];
        wdata_d = {NB{agu_i_rs2[7:0]}};
      end
      2'b01: begin
        misalgn_d = addr_d[0];
        wmask_d   = LANE_H << {addr_d[1], 1'b0};
        wdata_d   = {(NB/2){agu_i_rs2[15:0]}};
      end
      2'b10: begin
        misalgn_d = |addr_d[1:0];
        wmask_d   = '1;
      end
      default: misalgn_d = 1'b1;
    endcase
    if (misalgn_d || agu_i_load) wmask_d = '0;
  end

  // Response-side formatting: move the addressed lane down to bit 0, extend.
  assign shifted_d = agu_i_mem_rdata >> {cmd_addr_q[1:0], 3'b000};

  always_comb begin
    ld_data_d = shifted_d;
    case (cmd_size_q)
      2'b00:   ld_data_d = {{(XLEN-8){shifted_d[7] & ~cmd_usign_q}}, shifted_d[7:0]};
      2'b01:   ld_data_d = {{(XLEN-16){shifted_d[15] & ~cmd_usign_q}}, shifted_d[15:0]};
      default: ld_data_d = shifted_d;
    endcase
  end

  assign resp_err_d = agu_i_mem_err | cmd_misalgn_q;

  // Main sequencer. flushed_q remembers a flush that arrives after the
  // command was handed to mem_top, so the response is still drained but the
  // writeback beat is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_enable_q  <= 1'b0;
      cmd_read_q    <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_usign_q   <= 1'b0;
      cmd_size_q    <= 2'b00;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_wmask_q   <= '0;
      cmd_misalgn_q <= 1'b0;
      rd_idx_q      <= '0;
      mem_valid_q   <= 1'b0;
      flushed_q     <= 1'b0;
      wbck_valid_q  <= 1'b0;
      wbck_rd_en_q  <= 1'b0;
      wbck_err_q    <= 1'b0;
      wbck_rd_idx_q <= '0;
      wbck_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            cmd_enable_q  <= 1'b1;
            cmd_read_q    <= agu_i_load;
            cmd_write_q   <= agu_i_store;
            cmd_usign_q   <= agu_i_usign;
            cmd_size_q    <= agu_i_size;
            cmd_addr_q    <= addr_d;
            cmd_wdata_q   <= wdata_d;
            cmd_wmask_q   <= wmask_d;
            cmd_misalgn_q <= misalgn_d;
            rd_idx_q      <= agu_i_rd_idx;
            mem_valid_q   <= 1'b1;
            flushed_q     <= 1'b0;
            state_q       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (agu_i_mem_ready) begin
            mem_valid_q <= 1'b0;
            flushed_q   <= agu_i_flush;
            state_q     <= ST_WAIT;
          end else if (agu_i_flush) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (agu_i_mem_ready) begin
            flushed_q <= 1'b0;
            if (agu_i_flush || flushed_q) begin
              state_q <= ST_IDLE;
            end else begin
              wbck_valid_q  <= 1'b1;
              wbck_err_q    <= resp_err_d;
              wbck_rd_en_q  <= cmd_read_q & ~resp_err_d;
              wbck_rd_idx_q <= rd_idx_q;
              wbck_data_q   <= cmd_read_q ? ld_data_d : '0;
              state_q       <= ST_WBCK;
            end
          end else if (agu_i_flush) begin
            flushed_q <= 1'b1;
          end
        end
        ST_WBCK: begin
          if (agu_i_wbck_ready || agu_i_flush) begin
            wbck_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign agu_o_ready       = (state_q == ST_IDLE);
  assign agu_o_cmd_enable  = cmd_enable_q;
  assign agu_o_cmd_read    = cmd_read_q;
  assign agu_o_cmd_write   = cmd_write_q;
  assign agu_o_cmd_usign   = cmd_usign_q;
  assign agu_o_cmd_size    = cmd_size_q;
  assign agu_o_cmd_addr    = cmd_addr_q;
  assign agu_o_cmd_wdata   = cmd_wdata_q;
  assign agu_o_cmd_wmask   = cmd_wmask_q;
  assign agu_o_cmd_misalgn = cmd_misalgn_q;
  assign agu_o_mem_valid   = mem_valid_q;
  assign agu_o_wbck_valid  = wbck_valid_q;
  assign agu_o_wbck_rd_en  = wbck_rd_en_q;
  assign agu_o_wbck_rd_idx = wbck_rd_idx_q;
  assign agu_o_wbck_data   = wbck_data_q;
  assign agu_o_wbck_err    = wbck_err_q;

endmodule

// File: tb/tb_exu_agu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_exu_agu
// Directed, self-checking bench for exu_agu. Each scenario task drives its
// own stimulus and compares outputs against hand-computed values, sampling
// 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_exu_agu;

  logic        clk;
  logic        rst_n;
  logic        agu_i_valid;
  logic        agu_o_ready;
  logic        agu_i_load;
  logic        agu_i_store;
  logic        agu_i_usign;
  logic [1:0]  agu_i_size;
  logic [31:0] agu_i_rs1;
  logic [31:0] agu_i_rs2;
  logic [31:0] agu_i_imm;
  logic [4:0]  agu_i_rd_idx;
  logic        agu_i_flush;
  logic        agu_o_cmd_enable;
  logic        agu_o_cmd_read;
  logic        agu_o_cmd_write;
  logic        agu_o_cmd_usign;
  logic [1:0]  agu_o_cmd_size;
  logic [31:0] agu_o_cmd_addr;
  logic [31:0] agu_o_cmd_wdata;
  logic [3:0]  agu_o_cmd_wmask;
  logic        agu_o_cmd_misalgn;
  logic        agu_o_mem_valid;
  logic        agu_i_mem_ready;
  logic [31:0] agu_i_mem_rdata;
  logic        agu_i_mem_err;
  logic        agu_o_wbck_valid;
  logic        agu_i_wbck_ready;
  logic        agu_o_wbck_rd_en;
  logic [4:0]  agu_o_wbck_rd_idx;
  logic [31:0] agu_o_wbck_data;
  logic        agu_o_wbck_err;

  int checks = 0;
  int fails  = 0;

  exu_agu #(.XLEN(32), .PC_SIZE(32), .RFIDX_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .agu_i_valid       (agu_i_valid),
    .agu_o_ready       (agu_o_ready),
    .agu_i_load        (agu_i_load),
    .agu_i_store       (agu_i_store),
    .agu_i_usign       (agu_i_usign),
    .agu_i_size        (agu_i_size),
    .agu_i_rs1         (agu_i_rs1),
    .agu_i_rs2         (agu_i_rs2),
    .agu_i_imm         (agu_i_imm),
    .agu_i_rd_idx      (agu_i_rd_idx),
    .agu_i_flush       (agu_i_flush),
    .agu_o_cmd_enable  (agu_o_cmd_enable),
    .agu_o_cmd_read    (agu_o_cmd_read),
    .agu_o_cmd_write   (agu_o_cmd_write),
    .agu_o_cmd_usign   (agu_o_cmd_usign),
    .agu_o_cmd_size    (agu_o_cmd_size),
    .agu_o_cmd_addr    (agu_o_cmd_addr),
    .agu_o_cmd_wdata   (agu_o_cmd_wdata),
    .agu_o_cmd_wmask   (agu_o_cmd_wmask),
    .agu_o_cmd_misalgn (agu_o_cmd_misalgn),
    .agu_o_mem_valid   (agu_o_mem_valid),
    .agu_i_mem_ready   (agu_i_mem_ready),
    .agu_i_mem_rdata   (agu_i_mem_rdata),
    .agu_i_mem_err     (agu_i_mem_err),
    .agu_o_wbck_valid  (agu_o_wbck_valid),
    .agu_i_wbck_ready  (agu_i_wbck_ready),
    .agu_o_wbck_rd_en  (agu_o_wbck_rd_en),
    .agu_o_wbck_rd_idx (agu_o_wbck_rd_idx),
    .agu_o_wbck_data   (agu_o_wbck_data),
    .agu_o_wbck_err    (agu_o_wbck_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required end before 200000", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single accepting edge.
  task automatic issue(input logic ld, input logic st, input logic us,
                       input logic [1:0] sz, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [4:0] rd);
    agu_i_load   = ld;
    agu_i_store  = st;
    agu_i_usign  = us;
    agu_i_size   = sz;
    agu_i_rs1    = rs1;
    agu_i_rs2    = rs2;
    agu_i_imm    = imm;
    agu_i_rd_idx = rd;
    agu_i_valid  = 1'b1;
    step();
    agu_i_valid  = 1'b0;
    agu_i_load   = 1'b0;
    agu_i_store  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_write, agu_o_cmd_usign, agu_o_cmd_size,
         agu_o_cmd_addr, agu_o_cmd_wdata, agu_o_cmd_wmask, agu_o_cmd_misalgn, agu_o_mem_valid,
         agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_rd_idx, agu_o_wbck_data, agu_o_wbck_err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got addr=%h wdata=%h memv=%b wbv=%b, required all 0",
               agu_o_cmd_addr, agu_o_cmd_wdata, agu_o_mem_valid, agu_o_wbck_valid);
    end
    checks++;
    if (agu_o_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready: got %b required 1", agu_o_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({agu_o_ready, agu_o_mem_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL reset_release: got ready/memv=%b required 10", {agu_o_ready, agu_o_mem_valid});
    end
  endtask

  task automatic test_lw_aligned();
    agu_i_mem_ready  = 1'b1;
    agu_i_wbck_ready = 1'b1;
    agu_i_mem_rdata  = 32'hDEADBEEF;
    agu_i_mem_err    = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h4, 5'd7);
    checks++;
    if (agu_o_cmd_addr !== 32'h1004) begin
      fails++;
      $display("[TB] FAIL lw_addr: got %h required 00001004", agu_o_cmd_addr);
    end
    checks++;
    if ({agu_o_mem_valid, agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_write, agu_o_cmd_misalgn, agu_o_ready} !== 6'b111000) begin
      fails++;
      $display("[TB] FAIL lw_req_flags: got %b required 111000",
               {agu_o_mem_valid, agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_write, agu_o_cmd_misalgn, agu_o_ready});
    end
    checks++;
    if ({agu_o_cmd_size, agu_o_cmd_wmask} !== 6'b10_0000) begin
      fails++;
      $display("[TB] FAIL lw_size_wmask: got %b required 100000", {agu_o_cmd_size, agu_o_cmd_wmask});
    end
    step();
    checks++;
    if ({agu_o_mem_valid, agu_o_wbck_valid} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL lw_wait: got memv/wbv=%b required 00", {agu_o_mem_valid, agu_o_wbck_valid});
    end
    step();
    checks++;
    if ({agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err, agu_o_wbck_rd_idx} !== {3'b110, 5'd7}) begin
      fails++;
      $display("[TB] FAIL lw_wbck_flags: got v/en/err=%b idx=%0d required 110 idx=7",
               {agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err}, agu_o_wbck_rd_idx);
    end
    checks++;
    if (agu_o_wbck_data !== 32'hDEADBEEF) begin
      fails++;
      $display("[TB] FAIL lw_wbck_data: got %h required deadbeef", agu_o_wbck_data);
    end
    step();
    checks++;
    if ({agu_o_wbck_valid, agu_o_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL lw_idle: got wbv/ready=%b required 01", {agu_o_wbck_valid, agu_o_ready});
    end
  endtask

  task automatic test_lb_lbu();
    logic [31:0] expData [2];
    expData[0] = 32'hFFFFFF80;
    expData[1] = 32'h00000080;
    agu_i_mem_rdata = 32'h80112233;
    for (int u = 0; u < 2; u++) begin
      issue(1'b1, 1'b0, u[0], 2'b00, 32'h1000, 32'h0, 32'h3, 5'd5);
      checks++;
      if ({agu_o_cmd_addr, agu_o_cmd_misalgn, agu_o_cmd_usign} !== {32'h1003, 1'b0, u[0]}) begin
        fails++;
        $display("[TB] FAIL lb_req[%0d]: got addr=%h mis=%b us=%b required 00001003 0 %b",
                 u, agu_o_cmd_addr, agu_o_cmd_misalgn, agu_o_cmd_usign, u[0]);
      end
      step();
      step();
      checks++;
      if ({agu_o_wbck_data, agu_o_wbck_rd_en} !== {expData[u], 1'b1}) begin
        fails++;
        $display("[TB] FAIL lb_data[%0d]: got %h en=%b required %h en=1",
                 u, agu_o_wbck_data, agu_o_wbck_rd_en, expData[u]);
      end
      step();
    end
  endtask

  task automatic test_stores();
    issue(1'b0, 1'b1, 1'b0, 2'b01, 32'h2000, 32'h0000ABCD, 32'h2, 5'd0);
    checks++;
    if ({agu_o_cmd_wdata, agu_o_cmd_wmask} !== {32'hABCDABCD, 4'b1100}) begin
      fails++;
      $display("[TB] FAIL sh_wdata_wmask: got %h %b required abcdabcd 1100", agu_o_cmd_wdata, agu_o_cmd_wmask);
    end
    checks++;
    if ({agu_o_cmd_write, agu_o_cmd_read, agu_o_cmd_misalgn, agu_o_cmd_addr} !== {3'b100, 32'h2002}) begin
      fails++;
      $display("[TB] FAIL sh_cmd: got w/r/mis=%b addr=%h required 100 00002002",
               {agu_o_cmd_write, agu_o_cmd_read, agu_o_cmd_misalgn}, agu_o_cmd_addr);
    end
    step();
    step();
    checks++;
    if ({agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err, agu_o_wbck_data} !== {3'b100, 32'h0}) begin
      fails++;
      $display("[TB] FAIL sh_wbck: got v/en/err=%b data=%h required 100 00000000",
               {agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err}, agu_o_wbck_data);
    end
    step();
    issue(1'b0, 1'b1, 1'b0, 2'b00, 32'h1000, 32'h1234565A, 32'h1, 5'd0);
    checks++;
    if ({agu_o_cmd_wdata, agu_o_cmd_wmask} !== {32'h5A5A5A5A, 4'b0010}) begin
      fails++;
      $display("[TB] FAIL sb_wdata_wmask: got %h %b required 5a5a5a5a 0010", agu_o_cmd_wdata, agu_o_cmd_wmask);
    end
    repeat (3) step();
    // Address wraps modulo 2^32.
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'hFFFFFFFC, 32'h0, 32'h8, 5'd3);
    checks++;
    if ({agu_o_cmd_addr, agu_o_cmd_misalgn} !== {32'h4, 1'b0}) begin
      fails++;
      $display("[TB] FAIL addr_wrap: got %h mis=%b required 00000004 0", agu_o_cmd_addr, agu_o_cmd_misalgn);
    end
    repeat (3) step();
    // Valid with neither load nor store is ignored.
    issue(1'b0, 1'b0, 1'b0, 2'b10, 32'h7000, 32'h0, 32'h0, 5'd1);
    checks++;
    if ({agu_o_ready, agu_o_mem_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL nop_ignored: got ready/memv=%b required 10", {agu_o_ready, agu_o_mem_valid});
    end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h1, 5'd4);
    checks++;
    if ({agu_o_cmd_misalgn, agu_o_cmd_wmask, agu_o_mem_valid} !== 6'b1_0000_1) begin
      fails++;
      $display("[TB] FAIL mlw_cmd: got mis/wmask/memv=%b required 100001",
               {agu_o_cmd_misalgn, agu_o_cmd_wmask, agu_o_mem_valid});
    end
    step();
    step();
    checks++;
    if ({agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL mlw_wbck: got v/en/err=%b required 101",
               {agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err});
    end
    step();
    issue(1'b0, 1'b1, 1'b0, 2'b10, 32'h1000, 32'hFFFFFFFF, 32'h2, 5'd0);
    checks++;
    if ({agu_o_cmd_misalgn, agu_o_cmd_wmask} !== 5'b1_0000) begin
      fails++;
      $display("[TB] FAIL msw_cmd: got mis/wmask=%b required 10000", {agu_o_cmd_misalgn, agu_o_cmd_wmask});
    end
    repeat (3) step();
    issue(1'b0, 1'b1, 1'b0, 2'b11, 32'h1000, 32'hFFFFFFFF, 32'h0, 5'd0);
    checks++;
    if ({agu_o_cmd_misalgn, agu_o_cmd_wmask} !== 5'b1_0000) begin
      fails++;
      $display("[TB] FAIL size11_cmd: got mis/wmask=%b required 10000", {agu_o_cmd_misalgn, agu_o_cmd_wmask});
    end
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    agu_i_mem_ready = 1'b0;
    agu_i_mem_rdata = 32'h12345678;
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h3000, 32'h0, 32'h0, 5'd9);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) agu_i_mem_ready = 1'b1;
      checks++;
      if ({agu_o_mem_valid, agu_o_cmd_addr, agu_o_cmd_wmask, agu_o_cmd_read} !== {1'b1, 32'h3000, 4'b0000, 1'b1}) begin
        fails++;
        $display("[TB] FAIL req_hold[%0d]: got memv=%b addr=%h wmask=%b rd=%b required 1 00003000 0000 1",
                 i, agu_o_mem_valid, agu_o_cmd_addr, agu_o_cmd_wmask, agu_o_cmd_read);
      end
      if (i == 5) agu_i_wbck_ready = 1'b0;
      step();
    end
    checks++;
    if (agu_o_mem_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL req_single_accept: got memv=%b required 0", agu_o_mem_valid);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) agu_i_wbck_ready = 1'b1;
      checks++;
      if ({agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_data} !== {2'b11, 32'h12345678}) begin
        fails++;
        $display("[TB] FAIL wbck_hold[%0d]: got v/en=%b data=%h required 11 12345678",
                 i, {agu_o_wbck_valid, agu_o_wbck_rd_en}, agu_o_wbck_data);
      end
      step();
    end
    checks++;
    if ({agu_o_wbck_valid, agu_o_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL wbck_release: got wbv/ready=%b required 01", {agu_o_wbck_valid, agu_o_ready});
    end
  endtask

  task automatic test_mem_err();
    agu_i_mem_err = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 5'd2);
    step();
    step();
    checks++;
    if ({agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL mem_err: got v/en/err=%b required 101",
               {agu_o_wbck_valid, agu_o_wbck_rd_en, agu_o_wbck_err});
    end
    agu_i_mem_err = 1'b0;
    step();
  endtask

  task automatic test_flush();
    // Flush in IDLE blocks the accept.
    agu_i_flush = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 5'd1);
    agu_i_flush = 1'b0;
    checks++;
    if ({agu_o_ready, agu_o_mem_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL flush_idle: got ready/memv=%b required 10", {agu_o_ready, agu_o_mem_valid});
    end
    // Flush in REQ before the handshake drops the command.
    agu_i_mem_ready = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 5'd1);
    agu_i_flush = 1'b1;
    step();
    agu_i_flush = 1'b0;
    agu_i_mem_ready = 1'b1;
    checks++;
    if ({agu_o_ready, agu_o_mem_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL flush_req: got ready/memv=%b required 10", {agu_o_ready, agu_o_mem_valid});
    end
    repeat (3) step();
    checks++;
    if ({agu_o_mem_valid, agu_o_wbck_valid} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL flush_req_nowb: got memv/wbv=%b required 00", {agu_o_mem_valid, agu_o_wbck_valid});
    end
    // Flush in WAIT: response drains, no writeback.
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 5'd1);
    step();
    agu_i_mem_ready = 1'b0;
    agu_i_flush = 1'b1;
    step();
    agu_i_flush = 1'b0;
    agu_i_mem_ready = 1'b1;
    step();
    checks++;
    if ({agu_o_wbck_valid, agu_o_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL flush_wait: got wbv/ready=%b required 01", {agu_o_wbck_valid, agu_o_ready});
    end
    // Flush in WBCK drops the beat.
    agu_i_wbck_ready = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 5'd1);
    step();
    step();
    agu_i_flush = 1'b1;
    step();
    agu_i_flush = 1'b0;
    agu_i_wbck_ready = 1'b1;
    checks++;
    if ({agu_o_wbck_valid, agu_o_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL flush_wbck: got wbv/ready=%b required 01", {agu_o_wbck_valid, agu_o_ready});
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 5'd1);
    step();
    step();
    // Next instruction already waiting during the WBCK handshake cycle.
    agu_i_load  = 1'b1;
    agu_i_size  = 2'b10;
    agu_i_rs1   = 32'h5000;
    agu_i_imm   = 32'h0;
    agu_i_valid = 1'b1;
    checks++;
    if ({agu_o_wbck_valid, agu_o_ready} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL b2b_wbck: got wbv/ready=%b required 10", {agu_o_wbck_valid, agu_o_ready});
    end
    step();
    checks++;
    if ({agu_o_ready, agu_o_mem_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL b2b_gap: got ready/memv=%b required 10", {agu_o_ready, agu_o_mem_valid});
    end
    step();
    agu_i_valid = 1'b0;
    agu_i_load  = 1'b0;
    checks++;
    if ({agu_o_mem_valid, agu_o_cmd_addr} !== {1'b1, 32'h5000}) begin
      fails++;
      $display("[TB] FAIL b2b_accept: got memv=%b addr=%h required 1 00005000", agu_o_mem_valid, agu_o_cmd_addr);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h8, 5'd6);
    step();
    agu_i_mem_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_addr, agu_o_cmd_wmask, agu_o_cmd_misalgn,
         agu_o_mem_valid, agu_o_wbck_valid, agu_o_wbck_data, agu_o_wbck_err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid: got en=%b addr=%h memv=%b wbv=%b, required all 0",
               agu_o_cmd_enable, agu_o_cmd_addr, agu_o_mem_valid, agu_o_wbck_valid);
    end
    step();
    rst_n = 1'b1;
    agu_i_mem_ready = 1'b1;
    repeat (3) step();
    checks++;
    if ({agu_o_ready, agu_o_mem_valid, agu_o_wbck_valid} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL reset_no_replay: got ready/memv/wbv=%b required 100",
               {agu_o_ready, agu_o_mem_valid, agu_o_wbck_valid});
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    agu_i_valid      = 1'b0;
    agu_i_load       = 1'b0;
    agu_i_store      = 1'b0;
    agu_i_usign      = 1'b0;
    agu_i_size       = 2'b00;
    agu_i_rs1        = '0;
    agu_i_rs2        = '0;
    agu_i_imm        = '0;
    agu_i_rd_idx     = '0;
    agu_i_flush      = 1'b0;
    agu_i_mem_ready  = 1'b0;
    agu_i_mem_rdata  = '0;
    agu_i_mem_err    = 1'b0;
    agu_i_wbck_ready = 1'b0;

    test_reset();
    test_lw_aligned();
    test_lb_lbu();
    test_stores();
    test_misaligned();
    test_backpressure();
    test_mem_err();
    test_flush();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
